face_io_manager: RTL and testbench
==================================

Name: face_io_manager

Overview:
Parametrised bidirectional pad manager for NUM_FACES photodiode faces, each with a data pad and an envelope pad. Owns the tristate drive, multi-stage input synchronisation and dual-edge data capture. Adds envelope deglitching, edge pulses, envelope pulse-width measurement and output-to-input turnaround masking. Sits between the board pins and the per-face lighthouse decoders; pin LOC/IO_TYPE assignment lives in the LPF.

Parameters:
NUM_FACES, 2, number of faces (each face has one data pad and one envelope pad)
SYNC_STAGES, 2, posedge synchroniser flops on each input path (min 1)
FILTER_LEN, 3, consecutive disagreeing cycles required before filtered envelope toggles (min 1)
TURNAROUND, 4, cycles inputs stay masked after an oe falls (0 = no mask after release)
WIDTH_BITS, 16, envelope width counter width

Ports:
clk_96MHz  in  1  system clock, 96 MHz
reset  in  1  asynchronous, active-high reset
data_wire  inout  NUM_FACES  data pads
envelop_wire  inout  NUM_FACES  envelope pads
d_oe  in  NUM_FACES  data pad output enable (1 = drive)
d_out  in  NUM_FACES  data pad drive value
e_oe  in  NUM_FACES  envelope pad output enable
e_out  in  NUM_FACES  envelope pad drive value
d_in_first  out  NUM_FACES  synchronised data, posedge sample
d_in_second  out  NUM_FACES  d_in_first routed through a negedge flop, re-registered on posedge
e_in  out  NUM_FACES  filtered envelope
e_rise  out  NUM_FACES  1-cycle pulse on e_in 0->1
e_fall  out  NUM_FACES  1-cycle pulse on e_in 1->0
e_width  out  NUM_FACES*WIDTH_BITS  last envelope high time in cycles, face i at [i*WIDTH_BITS +: WIDTH_BITS]
e_width_valid  out  NUM_FACES  1-cycle pulse when e_width updates
e_width_ovf  out  NUM_FACES  width counter saturated in the reported pulse; held with e_width

Behaviour:
- Reset asynchronous, active-high: every output, sync flop, negedge flop, filter count, width counter, abort flag and turnaround counter is 0. Inputs are unmasked after reset.
- Pads: pad[i] driven with out[i] when oe[i]=1, else Z. Purely combinational, independent per pad.
- Turnaround: each pad has its own counter. While oe=1 the counter is loaded with TURNAROUND. After oe=0 it decrements to 0. Pad is masked while oe=1 or counter!=0; a masked pad feeds 0 into its synchroniser.
- Data path: SYNC_STAGES posedge flops produce d_in_first (latency SYNC_STAGES edges). A negedge flop captures d_in_first. d_in_second registers that flop on posedge, so it equals d_in_first delayed one cycle.
- Envelope filter: SYNC_STAGES posedge flops give es. At each edge:
  - es==e_in: count<=0.
  - else if count==FILTER_LEN-1: e_in<=~e_in, count<=0.
  - else count<=count+1.
  - Pad-to-e_in latency is SYNC_STAGES+FILTER_LEN edges. An es excursion shorter than FILTER_LEN cycles is rejected.
- e_rise/e_fall are registered at the same edge e_in toggles, high for exactly that one cycle.
- Width counter:
  - At the rise edge it loads 1.
  - While e_in=1 it increments each edge, saturating at 2^WIDTH_BITS-1; reaching saturation sets ovf_pending.
  - At the fall edge: e_width<=counter, e_width_ovf<=ovf_pending, e_width_valid<=1 for one cycle, then counter and ovf_pending are cleared.
  - Reported width equals the number of cycles e_in was high.
- Abort: if the envelope pad becomes masked while e_in=1, the abort flag sets. The subsequent e_fall still pulses, but e_width_valid is suppressed and e_width/e_width_ovf hold. Abort clears at the next rise.
- Simultaneous rise and mask: abort is set from the next edge.
- Faces are fully independent; no shared state between faces.
- Reset mid-pulse: no e_fall and no e_width_valid is generated.

Test Plan:
1. Reset, then data pad 0->1 at cycle 10 -> d_in_first rises at edge 12 and d_in_second at edge 13 (SYNC_STAGES=2); oe=0 throughout so the pad reads Z-pulled value.
2. Envelope high for 40 cycles, clean -> e_in rises 5 edges after the pad and e_rise pulses once; after fall, e_fall and e_width_valid pulse together with e_width=40 and ovf=0.
3. 2-cycle envelope glitch -> e_in stays 0 with no e_rise/e_fall; a 3-cycle glitch produces e_in high for exactly 3 cycles and e_width=3.
4. WIDTH_BITS=4 with a 20-cycle pulse -> e_width=15, e_width_ovf=1; a following 5-cycle pulse reports 5 with ovf=0.
5. Drive d_oe=1 for 10 cycles with d_out=1, then release to 0 -> pad shows 1 while driven; d_in_first stays 0 during drive and for 4 cycles after release plus sync latency.
6. Assert e_oe mid-pulse on face 1 while face 0 runs a 30-cycle pulse -> face 1 gets e_fall with no e_width_valid; face 0 reports e_width=30. Async reset mid-pulse clears all outputs immediately.

Source files
------------

// File: rtl/face_io_manager.sv
// Bidirectional pad manager for the photodiode faces.
// Per face: tristate drive for the data and envelope pads, turnaround masking after a release,
// synchronisers, dual-edge data capture, envelope deglitch filter, edge pulses and
// envelope high-time measurement with saturation and abort handling.
module face_io_manager #(
  parameter int unsigned NUM_FACES   = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3,
  parameter int unsigned TURNAROUND  = 4,
  parameter int unsigned WIDTH_BITS  = 16
) (
  input  logic                            clk_96MHz,
  input  logic                            reset,
  inout  wire  [NUM_FACES-1:0]            data_wire,
  inout  wire  [NUM_FACES-1:0]            envelop_wire,
  input  logic [NUM_FACES-1:0]            d_oe,
  input  logic [NUM_FACES-1:0]            d_out,
  input  logic [NUM_FACES-1:0]            e_oe,
  input  logic [NUM_FACES-1:0]            e_out,
  output logic [NUM_FACES-1:0]            d_in_first,
  output logic [NUM_FACES-1:0]            d_in_second,
  output logic [NUM_FACES-1:0]            e_in,
  output logic [NUM_FACES-1:0]            e_rise,
  output logic [NUM_FACES-1:0]            e_fall,
  output logic [NUM_FACES*WIDTH_BITS-1:0] e_width,
  output logic [NUM_FACES-1:0]            e_width_valid,
  output logic [NUM_FACES-1:0]            e_width_ovf
);

  localparam int unsigned TaW = (TURNAROUND > 0) ? $clog2(TURNAROUND + 1) : 1;
  localparam int unsigned FcW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [TaW-1:0]        TaLoad = TaW'(TURNAROUND);
  localparam logic [FcW-1:0]        FcLast = FcW'(FILTER_LEN - 1);
  localparam logic [WIDTH_BITS-1:0] WMax   = '1;

  for (genvar i = 0; i < NUM_FACES; i++) begin : g_face
    logic [TaW-1:0]         d_ta_q, d_ta_d, e_ta_q, e_ta_d;
    logic                   d_mask, e_mask, d_raw, e_raw;
    logic [SYNC_STAGES-1:0] d_sync_q, d_sync_d, e_sync_q, e_sync_d;
    logic                   d_neg_q, d_neg_d;
    logic                   d_second_q, d_second_d;
    logic                   e_in_q, e_in_d, e_rise_q, e_rise_d, e_fall_q, e_fall_d;
    logic [FcW-1:0]         fcnt_q, fcnt_d;
    logic [WIDTH_BITS-1:0]  wcnt_q, wcnt_d, width_q, width_d;
    logic                   ovf_pend_q, ovf_pend_d, width_ovf_q, width_ovf_d;
    logic                   width_valid_q, width_valid_d;
    logic                   abort_q, abort_d;
    logic                   es, toggle, abort_now;

    assign data_wire[i]    = d_oe[i] ? d_out[i] : 1'bz;
    assign envelop_wire[i] = e_oe[i] ? e_out[i] : 1'bz;

    // Turnaround counters: held at TURNAROUND while driving, then count down to zero.
    always_comb begin
      d_ta_d = d_ta_q;
      e_ta_d = e_ta_q;
      if (d_oe[i]) d_ta_d = TaLoad;
      else if (d_ta_q != '0) d_ta_d = d_ta_q - TaW'(1);
      if (e_oe[i]) e_ta_d = TaLoad;
      else if (e_ta_q != '0) e_ta_d = e_ta_q - TaW'(1);
    end

    // A masked pad presents 0 so our own drive never echoes back into the decoders.
    assign d_mask = d_oe[i] | (d_ta_q != '0);
    assign e_mask = e_oe[i] | (e_ta_q != '0);
    assign d_raw  = data_wire[i] & ~d_mask;
    assign e_raw  = envelop_wire[i] & ~e_mask;
    assign es     = e_sync_q[SYNC_STAGES-1];

    // Synchroniser shift chains and the negedge capture path.
    always_comb begin
      d_sync_d = d_sync_q;
      e_sync_d = e_sync_q;
      for (int k = SYNC_STAGES - 1; k > 0; k--) begin
        d_sync_d[k] = d_sync_q[k-1];
        e_sync_d[k] = e_sync_q[k-1];
      end
      d_sync_d[0] = d_raw;
      e_sync_d[0] = e_raw;
      d_neg_d     = d_sync_q[SYNC_STAGES-1];
      d_second_d  = d_neg_q;
    end

    // Envelope filter, edge pulses, width measurement and abort tracking.
    always_comb begin
      fcnt_d = '0;
      e_in_d = e_in_q;
      toggle = 1'b0;
      if (es != e_in_q) begin
        if (fcnt_q == FcLast) begin
          toggle = 1'b1;
          e_in_d = ~e_in_q;
        end else begin
          fcnt_d = fcnt_q + FcW'(1);
        end
      end
      e_rise_d = toggle & ~e_in_q;
      e_fall_d = toggle & e_in_q;

      // Abort is evaluated against the current mask so a mask on the fall edge also counts.
      abort_now = abort_q | (e_in_q & e_mask);
      abort_d   = e_rise_d ? 1'b0 : abort_now;

      wcnt_d        = wcnt_q;
      ovf_pend_d    = ovf_pend_q;
      width_d       = width_q;
      width_ovf_d   = width_ovf_q;
      width_valid_d = 1'b0;
      if (e_rise_d) begin
        wcnt_d     = WIDTH_BITS'(1);
        ovf_pend_d = (WIDTH_BITS'(1) == WMax);
      end else if (e_fall_d) begin
        if (!abort_now) begin
          width_d       = wcnt_q;
          width_ovf_d   = ovf_pend_q;
          width_valid_d = 1'b1;
        end
        wcnt_d     = '0;
        ovf_pend_d = 1'b0;
      end else if (e_in_q && (wcnt_q != WMax)) begin
        wcnt_d = wcnt_q + WIDTH_BITS'(1);
        if (wcnt_d == WMax) ovf_pend_d = 1'b1;
      end
    end

    // Posedge state.
    always_ff @(posedge clk_96MHz or posedge reset) begin
      if (reset) begin
        d_ta_q        <= '0;
        e_ta_q        <= '0;
        d_sync_q      <= '0;
        e_sync_q      <= '0;
        d_second_q    <= 1'b0;
        e_in_q        <= 1'b0;
        e_rise_q      <= 1'b0;
        e_fall_q      <= 1'b0;
        fcnt_q        <= '0;
        wcnt_q        <= '0;
        width_q       <= '0;
        ovf_pend_q    <= 1'b0;
        width_ovf_q   <= 1'b0;
        width_valid_q <= 1'b0;
        abort_q       <= 1'b0;
      end else begin
        d_ta_q        <= d_ta_d;
        e_ta_q        <= e_ta_d;
        d_sync_q      <= d_sync_d;
        e_sync_q      <= e_sync_d;
        d_second_q    <= d_second_d;
        e_in_q        <= e_in_d;
        e_rise_q      <= e_rise_d;
        e_fall_q      <= e_fall_d;
        fcnt_q        <= fcnt_d;
        wcnt_q        <= wcnt_d;
        width_q       <= width_d;
        ovf_pend_q    <= ovf_pend_d;
        width_ovf_q   <= width_ovf_d;
        width_valid_q <= width_valid_d;
        abort_q       <= abort_d;
      end
    end

    // Negedge capture of the synchronised data for the second-half sample.
    always_ff @(negedge clk_96MHz or posedge reset) begin
      if (reset) d_neg_q <= 1'b0;
      else       d_neg_q <= d_neg_d;
    end

    assign d_in_first[i]    = d_sync_q[SYNC_STAGES-1];
    assign d_in_second[i]   = d_second_q;
    assign e_in[i]          = e_in_q;
    assign e_rise[i]        = e_rise_q;
    assign e_fall[i]        = e_fall_q;
    assign e_width[i*WIDTH_BITS +: WIDTH_BITS] = width_q;
    assign e_width_valid[i] = width_valid_q;
    assign e_width_ovf[i]   = width_ovf_q;
  end

endmodule

// File: tb/tb_face_io_manager.sv
// Bench for face_io_manager: two instances (16-bit and 4-bit width counters) share stimulus;
// expectations come from pulse-level rules (latency, width, saturation, mask windows).
module tb_face_io_manager;
  localparam int NF = 2;
  localparam int S  = 2;
  localparam int F  = 3;
  localparam int T  = 4;
  localparam int WA = 16;
  localparam int WB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NF-1:0] d_oe, d_out, e_oe, e_out, tb_d, tb_e;
  wire  [NF-1:0] dw_a, ew_a, dw_b, ew_b;

  // Bench pad drivers release whenever the DUT drives the pad.
  for (genvar i = 0; i < NF; i++) begin : g_pad
    assign dw_a[i] = d_oe[i] ? 1'bz : tb_d[i];
    assign ew_a[i] = e_oe[i] ? 1'bz : tb_e[i];
    assign dw_b[i] = d_oe[i] ? 1'bz : tb_d[i];
    assign ew_b[i] = e_oe[i] ? 1'bz : tb_e[i];
  end

  logic [NF-1:0]    dfa, dsa, eia, era, efa, eva, eoa;
  logic [NF-1:0]    dfb, dsb, eib, erb, efb, evb, eob;
  logic [NF*WA-1:0] ewa;
  logic [NF*WB-1:0] ewb;

  face_io_manager #(.NUM_FACES(NF), .SYNC_STAGES(S), .FILTER_LEN(F), .TURNAROUND(T),
                    .WIDTH_BITS(WA)) dut_a (
    .clk_96MHz(clk), .reset(rst), .data_wire(dw_a), .envelop_wire(ew_a),
    .d_oe(d_oe), .d_out(d_out), .e_oe(e_oe), .e_out(e_out),
    .d_in_first(dfa), .d_in_second(dsa), .e_in(eia), .e_rise(era), .e_fall(efa),
    .e_width(ewa), .e_width_valid(eva), .e_width_ovf(eoa)
  );

  face_io_manager #(.NUM_FACES(NF), .SYNC_STAGES(S), .FILTER_LEN(F), .TURNAROUND(T),
                    .WIDTH_BITS(WB)) dut_b (
    .clk_96MHz(clk), .reset(rst), .data_wire(dw_b), .envelop_wire(ew_b),
    .d_oe(d_oe), .d_out(d_out), .e_oe(e_oe), .e_out(e_out),
    .d_in_first(dfb), .d_in_second(dsb), .e_in(eib), .e_rise(erb), .e_fall(efb),
    .e_width(ewb), .e_width_valid(evb), .e_width_ovf(eob)
  );

  int total = 0;
  int bad   = 0;

  // Envelope stimulus for a window: pad high for hl cycles, e_oe over [of, ot).
  int hl[NF], of[NF], ot[NF];
  // Observations per [dut][face].
  int o_rise[2][NF], o_fall[2][NF], o_valid[2][NF], o_hi[2][NF];
  int o_first[2][NF], o_rise_at[2][NF], o_fall_at[2][NF], o_valid_at[2][NF];
  // Reference model: last reported width/ovf per [dut][face].
  int exp_w[2][NF], exp_o[2][NF];

  function automatic int width_of(input int d, input int f);
    return (d == 0) ? int'(ewa[f*WA +: WA]) : int'(ewb[f*WB +: WB]);
  endfunction

  function automatic int ovf_of(input int d, input int f);
    return (d == 0) ? int'(eoa[f]) : int'(eob[f]);
  endfunction

  task automatic run_window(input int n);
    for (int d = 0; d < 2; d++) begin
      for (int f = 0; f < NF; f++) begin
        o_rise[d][f] = 0; o_fall[d][f] = 0; o_valid[d][f] = 0; o_hi[d][f] = 0;
        o_first[d][f] = -1; o_rise_at[d][f] = -1; o_fall_at[d][f] = -1;
        o_valid_at[d][f] = -1;
      end
    end
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      for (int f = 0; f < NF; f++) begin
        tb_e[f]  = (j < hl[f]);
        e_oe[f]  = (j >= of[f]) && (j < ot[f]);
        e_out[f] = 1'b0;
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        for (int f = 0; f < NF; f++) begin
          logic r, fl, v, hi;
          r  = (d == 0) ? era[f] : erb[f];
          fl = (d == 0) ? efa[f] : efb[f];
          v  = (d == 0) ? eva[f] : evb[f];
          hi = (d == 0) ? eia[f] : eib[f];
          if (hi) begin
            o_hi[d][f]++;
            if (o_first[d][f] < 0) o_first[d][f] = j;
          end
          if (r)  begin o_rise[d][f]++;  o_rise_at[d][f]  = j; end
          if (fl) begin o_fall[d][f]++;  o_fall_at[d][f]  = j; end
          if (v)  begin o_valid[d][f]++; o_valid_at[d][f] = j; end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    d_oe = '0; d_out = '0; e_oe = '0; e_out = '0; tb_d = '0; tb_e = '0;
    for (int d = 0; d < 2; d++)
      for (int f = 0; f < NF; f++) begin exp_w[d][f] = 0; exp_o[d][f] = 0; end
    repeat (3) @(negedge clk);
    total++;
    if ({dfa, dsa, eia, era, efa, ewa, eva, eoa} !== '0) begin
      bad++; $display("FAIL reset_a: got %h want 0", {dfa, dsa, eia, era, efa, ewa, eva, eoa});
    end
    total++;
    if ({dfb, dsb, eib, erb, efb, ewb, evb, eob} !== '0) begin
      bad++; $display("FAIL reset_b: got %h want 0", {dfb, dsb, eib, erb, efb, ewb, evb, eob});
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if ({dfa, eia, ewa, eva} !== '0) begin
      bad++; $display("FAIL post_reset_idle: got %h want 0", {dfa, eia, ewa, eva});
    end
  endtask

  task automatic test_data();
    logic [NF-1:0] hist[40];
    for (int j = 0; j < 40; j++) begin
      @(posedge clk); #1;
      tb_d = NF'($urandom_range(0, (1 << NF) - 1));
      hist[j] = tb_d;
      @(negedge clk);
      if (j >= 3) begin
        total++;
        if (dfa !== hist[j-2] || dfb !== hist[j-2]) begin
          bad++; $display("FAIL d_in_first j=%0d: got %b/%b want %b", j, dfa, dfb, hist[j-2]);
        end
        total++;
        if (dsa !== hist[j-3] || dsb !== hist[j-3]) begin
          bad++; $display("FAIL d_in_second j=%0d: got %b/%b want %b", j, dsa, dsb, hist[j-3]);
        end
      end
    end
  endtask

  task automatic test_turnaround();
    logic [NF-1:0] oe_h[64], pad_h[64];
    logic          oe1;
    logic          vis;
    logic          want;
    int            m;
    oe1 = 1'b0;
    for (int j = 0; j < 64; j++) begin
      @(posedge clk); #1;
      if (j >= 8 && $urandom_range(0, 3) == 0) oe1 = ~oe1;
      d_oe[0] = (j >= 10) && (j < 20);
      d_oe[1] = (j >= 8) ? oe1 : 1'b0;
      d_out   = NF'($urandom_range(0, (1 << NF) - 1));
      tb_d    = (j >= 10 && j < 30) ? '1 : NF'($urandom_range(0, (1 << NF) - 1));
      oe_h[j] = d_oe;
      pad_h[j] = tb_d;
      @(negedge clk);
      for (int f = 0; f < NF; f++) begin
        want = d_oe[f] ? d_out[f] : tb_d[f];
        total++;
        if (dw_a[f] !== want) begin
          bad++; $display("FAIL pad_value j=%0d f=%0d: got %b want %b", j, f, dw_a[f], want);
        end
        if (j >= 8) begin
          // Sample seen j-2 cycles in is visible only if no oe in the T+1 cycles ending there.
          m = j - S;
          vis = 1'b1;
          for (int k = m - T; k <= m; k++) if (oe_h[k][f]) vis = 1'b0;
          want = vis ? pad_h[m][f] : 1'b0;
          total++;
          if (dfa[f] !== want) begin
            bad++; $display("FAIL turnaround j=%0d f=%0d: got %b want %b", j, f, dfa[f], want);
          end
        end
      end
    end
    @(posedge clk); #1;
    d_oe = '0; tb_d = '0;
    repeat (T + S + 2) @(negedge clk);
  endtask

  task automatic test_pulse_pair(input string name, input int l0, input int l1);
    int n, wmax, len, ep;
    hl[0] = l0; hl[1] = l1;
    for (int f = 0; f < NF; f++) begin of[f] = 0; ot[f] = 0; end
    n = ((l0 > l1) ? l0 : l1) + S + F + 6;
    run_window(n);
    for (int d = 0; d < 2; d++) begin
      wmax = (d == 0) ? (1 << WA) - 1 : (1 << WB) - 1;
      for (int f = 0; f < NF; f++) begin
        len = hl[f];
        ep  = (len >= F) ? 1 : 0;
        if (ep == 1) begin
          exp_w[d][f] = (len < wmax) ? len : wmax;
          exp_o[d][f] = (len >= wmax) ? 1 : 0;
        end
        total++;
        if (o_rise[d][f] != ep || o_fall[d][f] != ep || o_valid[d][f] != ep) begin
          bad++; $display("FAIL %s d%0d f%0d edges: got r%0d f%0d v%0d want %0d", name, d, f,
                          o_rise[d][f], o_fall[d][f], o_valid[d][f], ep);
        end
        total++;
        if (o_hi[d][f] != ep * len) begin
          bad++; $display("FAIL %s d%0d f%0d high_time: got %0d want %0d", name, d, f,
                          o_hi[d][f], ep * len);
        end
        if (ep == 1) begin
          total++;
          if (o_first[d][f] != S + F || o_rise_at[d][f] != S + F ||
              o_valid_at[d][f] != o_fall_at[d][f] || o_fall_at[d][f] != len + S + F) begin
            bad++; $display("FAIL %s d%0d f%0d timing: got rise@%0d hi@%0d fall@%0d val@%0d want %0d/%0d",
                            name, d, f, o_rise_at[d][f], o_first[d][f], o_fall_at[d][f],
                            o_valid_at[d][f], S + F, len + S + F);
          end
        end
        total++;
        if (width_of(d, f) != exp_w[d][f] || ovf_of(d, f) != exp_o[d][f]) begin
          bad++; $display("FAIL %s d%0d f%0d width: got %0d ovf %0d want %0d ovf %0d", name, d, f,
                          width_of(d, f), ovf_of(d, f), exp_w[d][f], exp_o[d][f]);
        end
      end
    end
  endtask

  task automatic test_abort();
    int wmax;
    hl[0] = 30; of[0] = 0;  ot[0] = 0;
    hl[1] = 20; of[1] = 15; ot[1] = 20;
    run_window(30 + S + F + 6);
    for (int d = 0; d < 2; d++) begin
      wmax = (d == 0) ? (1 << WA) - 1 : (1 << WB) - 1;
      exp_w[d][0] = (30 < wmax) ? 30 : wmax;
      exp_o[d][0] = (30 >= wmax) ? 1 : 0;
      total++;
      if (o_valid[d][0] != 1 || width_of(d, 0) != exp_w[d][0] || ovf_of(d, 0) != exp_o[d][0]) begin
        bad++; $display("FAIL abort_face0 d%0d: got v%0d w%0d o%0d want v1 w%0d o%0d", d,
                        o_valid[d][0], width_of(d, 0), ovf_of(d, 0), exp_w[d][0], exp_o[d][0]);
      end
      total++;
      if (o_rise[d][1] != 1 || o_fall[d][1] != 1 || o_valid[d][1] != 0) begin
        bad++; $display("FAIL abort_edges d%0d: got r%0d f%0d v%0d want r1 f1 v0", d,
                        o_rise[d][1], o_fall[d][1], o_valid[d][1]);
      end
      total++;
      if (o_fall_at[d][1] != 15 + S + F) begin
        bad++; $display("FAIL abort_fall_time d%0d: got %0d want %0d", d, o_fall_at[d][1],
                        15 + S + F);
      end
      total++;
      if (width_of(d, 1) != exp_w[d][1] || ovf_of(d, 1) != exp_o[d][1]) begin
        bad++; $display("FAIL abort_hold d%0d: got %0d/%0d want %0d/%0d", d, width_of(d, 1),
                        ovf_of(d, 1), exp_w[d][1], exp_o[d][1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    hl[0] = 1000; hl[1] = 0;
    for (int f = 0; f < NF; f++) begin of[f] = 0; ot[f] = 0; end
    run_window(12);
    total++;
    if (eia[0] !== 1'b1) begin
      bad++; $display("FAIL reset_mid_pre: e_in got %b want 1", eia[0]);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({dfa, dsa, eia, era, efa, ewa, eva, eoa, eib, ewb, evb} !== '0) begin
      bad++; $display("FAIL reset_mid_async: got %h want 0", {eia, ewa, eva, eib, ewb});
    end
    tb_e = '0;
    for (int d = 0; d < 2; d++)
      for (int f = 0; f < NF; f++) begin exp_w[d][f] = 0; exp_o[d][f] = 0; end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hl[0] = 0;
    run_window(20);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (o_rise[d][0] != 0 || o_fall[d][0] != 0 || o_valid[d][0] != 0 ||
          width_of(d, 0) != 0) begin
        bad++; $display("FAIL reset_mid_after d%0d: got r%0d f%0d v%0d w%0d want all 0", d,
                        o_rise[d][0], o_fall[d][0], o_valid[d][0], width_of(d, 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_data();
    test_turnaround();
    test_pulse_pair("clean", 40, 25);
    test_pulse_pair("glitch", 2, 3);
    test_pulse_pair("saturate", 20, 40);
    test_pulse_pair("after_sat", 5, 15);
    test_abort();
    test_pulse_pair("post_abort", 0, 12);
    for (int r = 0; r < 10; r++) begin
      test_pulse_pair("random", $urandom_range(1, 40), $urandom_range(1, 40));
    end
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
